// File: rtl/uart_rx.sv
// UART receiver: 2-FF synchronised rx line, start/data/stop framing, parallel word out
// with one-cycle o_dv / o_err strobes. Define UART_RX_MAJORITY_EN for 2-of-3 sampling.
module uart_rx #(
  parameter int p_CLK_DIV  = 868,
  parameter int p_WORD_LEN = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_rx,
  output logic [p_WORD_LEN:0] o_data,
  output logic                o_dv,
  output logic                o_err,
  output logic                o_active
);

  localparam int CW = $clog2(p_CLK_DIV + 1);
  localparam int BW = $clog2(p_WORD_LEN + 1);
  localparam logic [CW-1:0] HALF     = CW'(p_CLK_DIV / 2);
  localparam logic [CW-1:0] LAST     = CW'(p_CLK_DIV);
  localparam logic [BW-1:0] BIT_LAST = BW'(p_WORD_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_CLEANUP, S_WAIT_HIGH
  } state_e;

  state_e              state_q, state_d;
  logic                rx_meta_q, rx_s_q;
  logic [CW-1:0]       clk_count_q, clk_count_d;
  logic [BW-1:0]       bit_count_q, bit_count_d;
  logic [p_WORD_LEN:0] shift_q, shift_d;
  logic [p_WORD_LEN:0] data_q, data_d;
  logic                err_q, err_d;
  logic                rx_lvl;   // line level used for edge/idle decisions
  logic                rx_samp;  // bit value used at sample points

`ifdef UART_RX_MAJORITY_EN
  // The FSM runs one cycle behind rx_s_q so the majority window is centred on its sample count.
  logic [1:0] hist_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) hist_q <= 2'b11;
    else       hist_q <= {hist_q[0], rx_s_q};
  end

  assign rx_lvl  = hist_q[0];
  assign rx_samp = (rx_s_q & hist_q[0]) | (rx_s_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
  assign rx_lvl  = rx_s_q;
  assign rx_samp = rx_s_q;
`endif

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= S_IDLE;
      clk_count_q <= '0;
      bit_count_q <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      rx_meta_q   <= i_rx;
      rx_s_q      <= rx_meta_q;
      state_q     <= state_d;
      clk_count_q <= clk_count_d;
      bit_count_q <= bit_count_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    state_d     = state_q;
    clk_count_d = clk_count_q;
    bit_count_d = bit_count_q;
    shift_d     = shift_q;
    data_d      = data_q;
    err_d       = err_q;
    o_active    = 1'b0;
    o_dv        = 1'b0;
    o_err       = 1'b0;

    case (state_q)
      S_IDLE: begin
        clk_count_d = '0;
        bit_count_d = '0;
        // The detection cycle itself is count 0 of the start bit.
        if (!rx_lvl) begin
          state_d     = S_START;
          clk_count_d = CW'(1);
        end
      end
      S_START: begin
        o_active    = 1'b1;
        clk_count_d = clk_count_q + 1'b1;
        if (clk_count_q == HALF) begin
          clk_count_d = '0;
          state_d     = rx_samp ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        o_active = 1'b1;
        if (clk_count_q == LAST) begin
          clk_count_d          = '0;
          shift_d[bit_count_q] = rx_samp;
          if (bit_count_q == BIT_LAST) begin
            bit_count_d = '0;
            state_d     = S_STOP;
          end else begin
            bit_count_d = bit_count_q + 1'b1;
          end
        end else begin
          clk_count_d = clk_count_q + 1'b1;
        end
      end
      S_STOP: begin
        o_active = 1'b1;
        if (clk_count_q == LAST) begin
          clk_count_d = '0;
          err_d       = !rx_samp;
          if (rx_samp) data_d = shift_q;
          state_d     = S_CLEANUP;
        end else begin
          clk_count_d = clk_count_q + 1'b1;
        end
      end
      S_CLEANUP: begin
        o_dv    = !err_q;
        o_err   = err_q;
        state_d = rx_lvl ? S_IDLE : S_WAIT_HIGH;
      end
      S_WAIT_HIGH: begin
        // A held-low (break) line must return high before a new start is accepted.
        if (rx_lvl) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_data = data_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx (p_CLK_DIV=9, p_WORD_LEN=8) with a queue scoreboard
// fed by the stimulus and drained by an o_dv monitor.
module tb_uart_rx;

  localparam int CLK_DIV  = 9;
  localparam int WORD_LEN = 8;
  localparam int T        = CLK_DIV + 1;
  localparam int H        = CLK_DIV / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  // i_rx drive -> r_rx_s low takes 2 cycles, then H + (W+2)*T + 1 to the o_dv cycle.
  localparam int DV_LAT = 2 + H + (WORD_LEN + 2) * T + 1 + EXTRA;

  logic                clk = 1'b0;
  logic                rst;
  logic                rx;
  logic [WORD_LEN:0]   data;
  logic                dv, err, active;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int dv_count = 0, err_count = 0;
  int dv_cyc = 0, prev_dv_cyc = 0;
  int start_cyc = 0;
  logic [WORD_LEN:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx #(.p_CLK_DIV(CLK_DIV), .p_WORD_LEN(WORD_LEN)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_rx    (rx),
    .o_data  (data),
    .o_dv    (dv),
    .o_err   (err),
    .o_active(active)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b, input bit glitch);
    if (glitch) begin
      rx = b;  tick(4);
      rx = ~b; tick(1);
      rx = b;  tick(T - 5);
    end else begin
      rx = b;  tick(T);
    end
  endtask

  task automatic send_frame(input logic [WORD_LEN:0] w, input logic stop_bit, input bit glitch);
    rx = 1'b0;
    tick(T);
    for (int i = 0; i <= WORD_LEN; i++) drive_bit(w[i], glitch);
    rx = stop_bit;
    tick(T);
    rx = 1'b1;
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (dv === 1'b1) begin
      dv_count++;
      prev_dv_cyc = dv_cyc;
      dv_cyc      = cyc;
      check("dv_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check("dv_data", data, exp_q.pop_front());
      check("dv_err_exclusive", err, 1'b0);
    end
    if (err === 1'b1) err_count++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    tick(3);
    @(negedge clk);
    check("reset_outputs", {data, dv, err, active}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Idle line for 100 cycles.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_outputs", {data, dv, err, active}, 0);
    end
    @(posedge clk); #1;

    // Good frame and its latency.
    exp_q.push_back(9'h0A5);
    start_cyc = cyc;
    send_frame(9'h0A5, 1'b1, 1'b0);
    tick(5);
    check("f1_dv_count", dv_count, 1);
    check("f1_err_count", err_count, 0);
    check("f1_data", data, 9'h0A5);
    check("f1_latency", dv_cyc - start_cyc, DV_LAT);

    // False start: 3 low cycles.
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(1);
    @(negedge clk);
    check("glitch_active_high", active, 1'b1);
    tick(10);
    @(negedge clk);
    check("glitch_active_low", active, 1'b0);
    check("glitch_dv_count", dv_count, 1);
    check("glitch_err_count", err_count, 0);
    @(posedge clk); #1;

    // Framing error then held-low line.
    send_frame(9'h1FF, 1'b0, 1'b0);
    rx = 1'b0;
    tick(40);
    @(negedge clk);
    check("break_no_retrigger", active, 1'b0);
    check("ferr_err_count", err_count, 1);
    check("ferr_dv_count", dv_count, 1);
    check("ferr_data_held", data, 9'h0A5);
    @(posedge clk); #1;
    tick(10);
    rx = 1'b1;
    tick(20);
    check("break_release_active", active, 1'b0);
    check("break_err_count", err_count, 1);

    // Back-to-back frames, zero gap.
    exp_q.push_back(9'h001);
    exp_q.push_back(9'h100);
    start_cyc = cyc;
    send_frame(9'h001, 1'b1, 1'b0);
    send_frame(9'h100, 1'b1, 1'b0);
    tick(5);
    check("b2b_dv_count", dv_count, 3);
    check("b2b_spacing", dv_cyc - prev_dv_cyc, 11 * T);
    check("b2b_latency", dv_cyc - start_cyc, DV_LAT + 11 * T);
    check("b2b_data", data, 9'h100);

    // Reset during data bit 4 of 9'h155.
    rx = 1'b0;
    tick(T);
    for (int i = 0; i < 4; i++) drive_bit(1'(9'h155 >> i), 1'b0);
    rx = 1'b1;
    tick(5);
    rst = 1'b1;
    #1;
    check("midrst_outputs", {data, dv, err, active}, 0);
    tick(3);
    rst = 1'b0;
    tick(20);
    check("midrst_no_strobe", dv_count + err_count, 4);
    exp_q.push_back(9'h0F0);
    send_frame(9'h0F0, 1'b1, 1'b0);
    tick(5);
    check("post_rst_dv_count", dv_count, 4);
    check("post_rst_data", data, 9'h0F0);

`ifdef UART_RX_MAJORITY_EN
    // Single-cycle glitches at every bit centre must be voted out.
    exp_q.push_back(9'h0A5);
    exp_q.push_back(9'h15A);
    send_frame(9'h0A5, 1'b1, 1'b1);
    send_frame(9'h15A, 1'b1, 1'b1);
    tick(5);
    check("maj_dv_count", dv_count, 6);
    check("maj_err_count", err_count, 1);
    check("maj_data", data, 9'h15A);
`endif

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
